// File: rtl/irq_pending_if.sv
// Request/mask inputs and the valid/ack presentation port of the interrupt pending controller.
// The master side drives requests and acknowledges; the slave side is the controller.
interface irq_pending_if #(
   parameter int N = 4
);
   localparam int W = $clog2(N);

   logic [N-1:0] req;
   logic [N-1:0] mask;
   logic         en;
   logic         irq_ack;
   logic         irq_valid;
   logic [W-1:0] irq_id;
   logic [N-1:0] pending;
   logic [N-1:0] missed;

   modport master (
      output req, mask, en, irq_ack,
      input  irq_valid, irq_id, pending, missed
   );

   modport slave (
      input  req, mask, en, irq_ack,
      output irq_valid, irq_id, pending, missed
   );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Rising-edge interrupt capture with per-line mask and a highest-index-first valid/ack presenter.
// Feeds the downstream priority encoder stage using the same priority order.
module irq_pending_ctrl #(
   parameter int N = 4
) (
   input  logic          clk,
   input  logic          reset,
   irq_pending_if.slave  bus
);
   localparam int W = $clog2(N);

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t       state;
   logic [N-1:0] req_d;
   logic [N-1:0] pending_r;
   logic [N-1:0] missed_r;
   logic         irq_valid_r;
   logic [W-1:0] irq_id_r;

   logic [N-1:0] rise;
   logic [N-1:0] cand;
   logic [N-1:0] clr;
   logic [W-1:0] sel;
   logic         any_cand;

   always_comb begin
      rise     = bus.req & ~req_d;
      cand     = pending_r & bus.mask;
      any_cand = |cand;
      // Ascending scan so the highest set index is the one left in sel.
      sel = '0;
      for (int i = 0; i < N; i++) begin
         if (cand[i]) sel = W'(i);
      end
      clr = '0;
      if (state == PRESENT && bus.irq_ack) clr[irq_id_r] = 1'b1;
   end

   // req_d resets high so a line already asserted when reset releases is not taken as an event.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         irq_valid_r <= 1'b0;
         irq_id_r    <= '0;
         pending_r   <= '0;
         missed_r    <= '0;
         req_d       <= '1;
      end else begin
         req_d     <= bus.req;
         pending_r <= (pending_r & ~clr) | rise;
         missed_r  <= missed_r | (rise & pending_r & ~clr);
         case (state)
            IDLE: begin
               if (bus.en && any_cand) begin
                  state       <= PRESENT;
                  irq_valid_r <= 1'b1;
                  irq_id_r    <= sel;
               end
            end
            PRESENT: begin
               if (bus.irq_ack) begin
                  state       <= IDLE;
                  irq_valid_r <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.irq_valid = irq_valid_r;
   assign bus.irq_id    = irq_id_r;
   assign bus.pending   = pending_r;
   assign bus.missed    = missed_r;
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Scoreboard bench for irq_pending_ctrl: a driver runs a behavioural model and queues expectations,
// a monitor compares the DUT against them after every clock edge.
module tb_irq_pending_ctrl;
   localparam int N = 4;
   localparam int W = $clog2(N);

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   irq_pending_if #(.N(N)) bus();
   irq_pending_ctrl #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      logic         valid;
      logic [W-1:0] id;
      logic [N-1:0] pend;
      logic [N-1:0] miss;
   } snap_t;

   snap_t snap_q[$];
   int    pres_q[$];
   int    checks   = 0;
   int    failures = 0;

   // behavioural model state
   bit m_pend[N];
   bit m_miss[N];
   bit m_prev[N];
   bit m_valid;
   int m_id;

   logic [N-1:0] g_req;
   logic [N-1:0] g_mask;
   logic         g_en;
   logic         rst_drv;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 1'b0;
         m_miss[i] = 1'b0;
         m_prev[i] = 1'b1;
      end
      m_valid = 1'b0;
      m_id    = 0;
   endtask

   task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] m,
                             input logic e, input logic a);
      int served;
      int best;
      bit ev;
      served = -1;
      best   = -1;
      if (m_valid) begin
         if (a) begin
            served  = m_id;
            m_valid = 1'b0;
         end
      end else if (e) begin
         for (int i = N - 1; i >= 0; i--)
            if (best < 0 && m_pend[i] && m[i]) best = i;
         if (best >= 0) begin
            m_valid = 1'b1;
            m_id    = best;
            pres_q.push_back(best);
         end
      end
      for (int i = 0; i < N; i++) begin
         ev = r[i] && !m_prev[i];
         if (ev && m_pend[i] && i != served) m_miss[i] = 1'b1;
         m_pend[i] = (m_pend[i] && i != served) || ev;
         m_prev[i] = r[i];
      end
   endtask

   function automatic snap_t model_snap();
      snap_t s;
      s.valid = m_valid;
      s.id    = W'(m_id);
      for (int i = 0; i < N; i++) begin
         s.pend[i] = m_pend[i];
         s.miss[i] = m_miss[i];
      end
      return s;
   endfunction

   // Drives one cycle of inputs at the falling edge and records what the next rising edge must yield.
   task automatic step(input logic a);
      @(negedge clk);
      reset       = rst_drv;
      bus.req     = g_req;
      bus.mask    = g_mask;
      bus.en      = g_en;
      bus.irq_ack = a;
      if (rst_drv) model_reset();
      else model_step(g_req, g_mask, g_en, a);
      snap_q.push_back(model_snap());
   endtask

   task automatic pulse(input logic [N-1:0] bits);
      g_req = bits;
      step(1'b0);
      g_req = '0;
   endtask

   task automatic wait_valid(input int max_cycles);
      int n;
      n = 0;
      while (!m_valid && n < max_cycles) begin
         step(1'b0);
         n++;
      end
      checks++;
      if (!m_valid) begin
         failures++;
         $display("FAIL wait_valid_timeout t=%0t got=0 exp=1", $time);
      end
   endtask

   // monitor
   initial begin
      snap_t s;
      logic  prev_v;
      int    exp_id;
      prev_v = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            chk("snap_valid",   32'(bus.irq_valid), 32'(s.valid));
            chk("snap_id",      32'(bus.irq_id),    32'(s.id));
            chk("snap_pending", 32'(bus.pending),   32'(s.pend));
            chk("snap_missed",  32'(bus.missed),    32'(s.miss));
         end
         if (bus.irq_valid === 1'b1 && prev_v !== 1'b1) begin
            if (pres_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL pres_unexpected t=%0t got=%0d exp=none", $time, bus.irq_id);
            end else begin
               exp_id = pres_q.pop_front();
               chk("pres_id", 32'(bus.irq_id), 32'(exp_id));
            end
         end
         prev_v = bus.irq_valid;
      end
   end

   initial begin
      reset       = 1'b1;
      rst_drv     = 1'b1;
      g_req       = 4'b1111;
      g_mask      = 4'b1111;
      g_en        = 1'b1;
      bus.req     = g_req;
      bus.mask    = g_mask;
      bus.en      = g_en;
      bus.irq_ack = 1'b0;
      model_reset();

      // reset held with all requests high, then released with them still high
      repeat (3) step(1'b0);
      chk("rst_valid",   32'(bus.irq_valid), 32'd0);
      chk("rst_pending", 32'(bus.pending),   32'd0);
      chk("rst_missed",  32'(bus.missed),    32'd0);
      rst_drv = 1'b0;
      repeat (4) step(1'b0);
      chk("rel_pending", 32'(bus.pending),   32'd0);
      chk("rel_valid",   32'(bus.irq_valid), 32'd0);
      g_req = '0;
      repeat (2) step(1'b0);

      // single event on line 1
      pulse(4'b0010);
      step(1'b0);
      chk("single_pend", 32'(bus.pending), 32'b0010);
      step(1'b0);
      chk("single_valid", 32'(bus.irq_valid), 32'd1);
      chk("single_id",    32'(bus.irq_id),    32'd1);
      step(1'b1);
      step(1'b0);
      chk("single_ack_pend",  32'(bus.pending),   32'd0);
      chk("single_ack_valid", 32'(bus.irq_valid), 32'd0);

      // priority: lines 0 and 2 together
      pulse(4'b0101);
      wait_valid(5);
      step(1'b0);
      chk("prio_first", 32'(bus.irq_id), 32'd2);
      step(1'b1);
      wait_valid(5);
      step(1'b0);
      chk("prio_second", 32'(bus.irq_id), 32'd0);
      step(1'b1);
      step(1'b0);

      // masked line stays pending until unmasked
      g_mask = 4'b1011;
      pulse(4'b0100);
      repeat (3) step(1'b0);
      chk("mask_pend",  32'(bus.pending),   32'b0100);
      chk("mask_valid", 32'(bus.irq_valid), 32'd0);
      g_mask = 4'b1111;
      step(1'b0);
      step(1'b0);
      chk("unmask_id", 32'(bus.irq_id), 32'd2);
      step(1'b1);
      step(1'b0);

      // missed event, then set-wins on the ack cycle
      g_en = 1'b0;
      pulse(4'b1000);
      step(1'b0);
      pulse(4'b1000);
      step(1'b0);
      chk("missed", 32'(bus.missed), 32'b1000);
      g_en = 1'b1;
      step(1'b0);
      g_req = 4'b1000;
      step(1'b1);
      g_req = '0;
      step(1'b0);
      chk("setwin_pend", 32'(bus.pending[3]), 32'd1);
      chk("setwin_miss", 32'(bus.missed),     32'b1000);
      wait_valid(5);
      step(1'b0);
      chk("setwin_reissue", 32'(bus.irq_id), 32'd3);
      step(1'b1);
      step(1'b0);

      // freeze while en and mask drop mid-presentation
      pulse(4'b0010);
      wait_valid(5);
      step(1'b0);
      g_en   = 1'b0;
      g_mask = 4'b0000;
      pulse(4'b0100);
      repeat (3) step(1'b0);
      chk("freeze_id",    32'(bus.irq_id),    32'd1);
      chk("freeze_valid", 32'(bus.irq_valid), 32'd1);
      step(1'b1);
      step(1'b0);
      g_en   = 1'b1;
      g_mask = 4'b1111;
      wait_valid(5);
      step(1'b0);
      step(1'b1);

      // asynchronous reset mid-presentation
      pulse(4'b0001);
      wait_valid(5);
      step(1'b0);
      rst_drv = 1'b1;
      step(1'b0);
      #1;
      chk("async_valid", 32'(bus.irq_valid), 32'd0);
      chk("async_pend",  32'(bus.pending),   32'd0);
      chk("async_miss",  32'(bus.missed),    32'd0);
      step(1'b0);
      rst_drv = 1'b0;
      repeat (2) step(1'b0);

      // randomized traffic
      for (int c = 0; c < 2000; c++) begin
         logic a;
         g_req = g_req ^ (N'($urandom) & N'($urandom));
         if (c % 40 == 0) g_mask = ($urandom_range(0, 2) == 0) ? N'($urandom) : '1;
         g_en    = ($urandom_range(0, 9) != 0);
         a       = m_valid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         rst_drv = ($urandom_range(0, 299) == 0);
         step(a);
      end

      // drain
      rst_drv = 1'b0;
      g_req   = '0;
      g_mask  = '1;
      g_en    = 1'b0;
      repeat (8) step(m_valid);
      @(posedge clk);
      #4;
      chk("pres_drained", 32'(pres_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
